// File: rtl/fifo_arbiter_pkg.sv
// Shared types and defaults for the two-in / two-out FIFO arbiter.
package fifo_arbiter_pkg;

  localparam int DATA_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_rr_grant.sv
// Combinational grant selection between the two upstream FIFOs.
// Build macro FIFO_ARBITER_STRICT_PRIO_EN: in0 always wins; otherwise round-robin.
module arb_rr_grant (
  input  logic in0_empty,
  input  logic in1_empty,
  input  logic block,
  input  logic ptr,
  output logic gnt0,
  output logic gnt1
);

  logic req0;
  logic req1;

  assign req0 = !in0_empty && !block;
  assign req1 = !in1_empty && !block;

`ifdef FIFO_ARBITER_STRICT_PRIO_EN
  always_comb begin
    gnt0 = req0;
    gnt1 = req1 && !req0;
  end
`else
  // ptr names the preferred input when both request (0 = in0, 1 = in1).
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = !ptr;
      gnt1 = ptr;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end
`endif

endmodule

// File: rtl/fifo_arbiter.sv
// Moves words from two upstream FIFOs to two downstream FIFOs, routed on the word MSB.
// Build macro FIFO_ARBITER_STRICT_PRIO_EN selects strict in0 priority instead of round-robin.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_empty,
  input  logic              in1_empty,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in0_rd_enb,
  output logic              in1_rd_enb,
  input  logic              out0_alm_full,
  input  logic              out1_alm_full,
  output logic              out0_wr_enb,
  output logic              out1_wr_enb,
  output logic [DATA_W-1:0] out_data,
  output logic              idle,
  output logic [1:0]        state_dbg
);

  // Handshake: inX_rd_enb pops one word, valid on inX_data the next cycle;
  // outY_wr_enb pushes out_data with no ready -- alm_full gates new grants only,
  // leaving room downstream for the two words that may already be in flight.

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              ptr_q;
  logic [1:0]        rd_q;
  logic              block;
  logic              gnt0;
  logic              gnt1;
  logic              cap_vld;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] out_data_q;
  logic              wr0_q;
  logic              wr1_q;

  assign block = (state_q == ST_RESET) || out0_alm_full || out1_alm_full;

  arb_rr_grant u_grant (
    .in0_empty (in0_empty),
    .in1_empty (in1_empty),
    .block     (block),
    .ptr       (ptr_q),
    .gnt0      (gnt0),
    .gnt1      (gnt1)
  );

  assign in0_rd_enb = gnt0;
  assign in1_rd_enb = gnt1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else if (gnt0) begin
      ptr_q <= 1'b1;
    end else if (gnt1) begin
      ptr_q <= 1'b0;
    end
  end

  // Stage 1 remembers which FIFO was popped; its data is on the bus this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= 2'b00;
    end else begin
      rd_q <= {gnt1, gnt0};
    end
  end

  assign cap_vld  = |rd_q;
  assign cap_data = rd_q[1] ? in1_data : in0_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q <= '0;
      wr0_q      <= 1'b0;
      wr1_q      <= 1'b0;
    end else begin
      if (cap_vld) begin
        out_data_q <= cap_data;
      end
      wr0_q <= cap_vld && !cap_data[DATA_W-1];
      wr1_q <= cap_vld && cap_data[DATA_W-1];
    end
  end

  assign out_data    = out_data_q;
  assign out0_wr_enb = wr0_q;
  assign out1_wr_enb = wr1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!gnt0 && !gnt1 && !cap_vld && !wr0_q && !wr1_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  assign idle      = (state_q == ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed scoreboard bench for fifo_arbiter; expectations follow FIFO_ARBITER_STRICT_PRIO_EN.
module tb_fifo_arbiter;
  import fifo_arbiter_pkg::*;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in0_empty = 1'b1;
  logic         in1_empty = 1'b1;
  logic [W-1:0] in0_data = '0;
  logic [W-1:0] in1_data = '0;
  logic         in0_rd_enb, in1_rd_enb;
  logic         out0_alm_full, out1_alm_full;
  logic         out0_wr_enb, out1_wr_enb;
  logic [W-1:0] out_data;
  logic         idle;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int wr_cnt = 0;
  int gnt_cnt = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W+1:0] exp_q[$];
  logic         gnt_q[$];
  int           lat_q[$];

  fifo_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .in0_empty     (in0_empty),
    .in1_empty     (in1_empty),
    .in0_data      (in0_data),
    .in1_data      (in1_data),
    .in0_rd_enb    (in0_rd_enb),
    .in1_rd_enb    (in1_rd_enb),
    .out0_alm_full (out0_alm_full),
    .out1_alm_full (out1_alm_full),
    .out0_wr_enb   (out0_wr_enb),
    .out1_wr_enb   (out1_wr_enb),
    .out_data      (out_data),
    .idle          (idle),
    .state_dbg     (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // upstream FIFO models: pop on rd_enb, data valid next cycle
  always @(posedge clk) begin
    if (in0_rd_enb && q0.size() > 0) in0_data <= q0.pop_front();
    if (in1_rd_enb && q1.size() > 0) in1_data <= q1.pop_front();
    in0_empty <= (q0.size() == 0);
    in1_empty <= (q1.size() == 0);
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic dest, input logic [W-1:0] d);
    exp_q.push_back({dest, !dest, d});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic         g;
    logic [W+1:0] e;
    int           lc;
    if (in0_rd_enb || in1_rd_enb) begin
      gnt_cnt++;
      chk(!(in0_rd_enb && in1_rd_enb) && !out0_alm_full && !out1_alm_full &&
          !(in0_rd_enb && in0_empty) && !(in1_rd_enb && in1_empty),
          "rd_legal", {in1_empty, in0_empty, in1_rd_enb, in0_rd_enb}, 0);
      if (gnt_q.size() == 0) begin
        chk(1'b0, "gnt_extra", {in1_rd_enb, in0_rd_enb}, 0);
      end else begin
        g = gnt_q.pop_front();
        chk({in1_rd_enb, in0_rd_enb} == {g, !g}, "gnt_src", {in1_rd_enb, in0_rd_enb}, {g, !g});
      end
      lat_q.push_back(cyc + 2);
    end
    if (out0_wr_enb || out1_wr_enb) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk(1'b0, "wr_extra", {out1_wr_enb, out0_wr_enb, out_data}, 0);
      end else begin
        e = exp_q.pop_front();
        chk({out1_wr_enb, out0_wr_enb, out_data} == e, "wr_word", {out1_wr_enb, out0_wr_enb, out_data}, e);
      end
      if (lat_q.size() == 0) begin
        chk(1'b0, "wr_lat_nogrant", cyc, 0);
      end else begin
        lc = lat_q.pop_front();
        chk(cyc == lc, "wr_latency", cyc, lc);
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    lat_q.delete();
  endtask

  task automatic wait_gnt(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in0_rd_enb || in1_rd_enb) && n < 20);
    chk(in0_rd_enb || in1_rd_enb, name, n, 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!idle && n < 40);
    chk(idle == 1'b1, name, n, 0);
  endtask

  task automatic check_drained(input string name);
    chk(exp_q.size() == 0 && gnt_q.size() == 0, name, {exp_q.size(), gnt_q.size()}, 0);
  endtask

  initial begin
    int wb;
    int gb;
    rst = 1'b1;
    out0_alm_full = 1'b0;
    out1_alm_full = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk({in1_rd_enb, in0_rd_enb, out1_wr_enb, out0_wr_enb} == 4'b0, "rst_strobes",
        {in1_rd_enb, in0_rd_enb, out1_wr_enb, out0_wr_enb}, 0);
    chk(out_data == '0, "rst_out_data", out_data, 0);
    chk(idle == 1'b0, "rst_idle", idle, 0);
    chk(state_dbg == ST_RESET, "rst_state", state_dbg, ST_RESET);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); chk(idle == 1'b0, "rel_still_reset", idle, 0);
    @(negedge clk); chk(idle == 1'b1, "rel_idle", idle, 1);

    // single input, two words, back-to-back reads, routed to both outputs
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b0);
    exp_wr(1'b0, 10'h005); exp_wr(1'b1, 10'h20A);
    @(posedge clk); #1;
    q0.push_back(10'h005); q0.push_back(10'h20A);
    wait_gnt("t1_gnt_timeout");
    chk(in0_rd_enb == 1'b1, "t1_rd_n", in0_rd_enb, 1);
    @(negedge clk); chk(in0_rd_enb == 1'b1, "t1_rd_n1", in0_rd_enb, 1);
    @(negedge clk); chk(in0_rd_enb == 1'b0, "t1_rd_n2", in0_rd_enb, 0);
    wait_idle("t1_idle_timeout");
    check_drained("t1_drain");

    // both inputs with three words each
    do_reset();
`ifdef FIFO_ARBITER_STRICT_PRIO_EN
    foreach (gnt_q[i]) ;
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b0); gnt_q.push_back(1'b0);
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b1); gnt_q.push_back(1'b1);
    exp_wr(1'b0, 10'h001); exp_wr(1'b1, 10'h202); exp_wr(1'b0, 10'h003);
    exp_wr(1'b1, 10'h211); exp_wr(1'b0, 10'h012); exp_wr(1'b1, 10'h213);
`else
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
    exp_wr(1'b0, 10'h001); exp_wr(1'b1, 10'h211); exp_wr(1'b1, 10'h202);
    exp_wr(1'b0, 10'h012); exp_wr(1'b0, 10'h003); exp_wr(1'b1, 10'h213);
`endif
    q0.push_back(10'h001); q0.push_back(10'h202); q0.push_back(10'h003);
    q1.push_back(10'h211); q1.push_back(10'h012); q1.push_back(10'h213);
    wait_gnt("t2_gnt_timeout");
    wait_idle("t2_idle_timeout");
    chk(cyc - last_wr_cyc == 2, "t2_idle_lat", cyc - last_wr_cyc, 2);
    check_drained("t2_drain");

    // alm_full blocks new grants but in-flight words still land
    do_reset();
`ifdef FIFO_ARBITER_STRICT_PRIO_EN
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b0); gnt_q.push_back(1'b0);
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b1);
    exp_wr(1'b0, 10'h004); exp_wr(1'b0, 10'h006); exp_wr(1'b0, 10'h008);
    exp_wr(1'b1, 10'h207); exp_wr(1'b1, 10'h209);
`else
    gnt_q.push_back(1'b0); gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
    exp_wr(1'b0, 10'h004); exp_wr(1'b1, 10'h207); exp_wr(1'b0, 10'h006);
    exp_wr(1'b1, 10'h209); exp_wr(1'b0, 10'h008);
`endif
    q0.push_back(10'h004); q0.push_back(10'h006); q0.push_back(10'h008);
    q1.push_back(10'h207); q1.push_back(10'h209);
    wait_gnt("t3_gnt_timeout");
    @(posedge clk); #1;
    @(posedge clk); #1 out1_alm_full = 1'b1;
    wb = wr_cnt;
    gb = gnt_cnt;
    repeat (4) @(negedge clk);
    chk(gnt_cnt == gb, "t3_blocked", gnt_cnt - gb, 0);
    chk(wr_cnt - wb == 2, "t3_inflight", wr_cnt - wb, 2);
    @(posedge clk); #1 out1_alm_full = 1'b0;
    @(negedge clk);
    chk(in0_rd_enb || in1_rd_enb, "t3_resume", {in1_rd_enb, in0_rd_enb}, 1);
    wait_idle("t3_idle_timeout");
    check_drained("t3_drain");

    // reset the cycle after a grant discards the in-flight word
    do_reset();
    gnt_q.push_back(1'b0);
    q0.push_back(10'h1AA);
    wait_gnt("t4_gnt_timeout");
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk({in1_rd_enb, in0_rd_enb, out1_wr_enb, out0_wr_enb} == 4'b0, "t4_strobes",
        {in1_rd_enb, in0_rd_enb, out1_wr_enb, out0_wr_enb}, 0);
    chk(out_data == '0, "t4_out_data", out_data, 0);
    chk(idle == 1'b0, "t4_idle_in_rst", idle, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    lat_q.delete();
    wb = wr_cnt;
    @(negedge clk); chk(idle == 1'b0, "t4_rel_reset", idle, 0);
    @(negedge clk); chk(idle == 1'b1, "t4_rel_idle", idle, 1);
    repeat (4) @(negedge clk);
    chk(wr_cnt == wb, "t4_no_wr", wr_cnt - wb, 0);
    check_drained("t4_drain");

    // single word 0x3FF: exactly one read, routed to out1
    do_reset();
    gnt_q.push_back(1'b0);
    exp_wr(1'b1, 10'h3FF);
    gb = gnt_cnt;
    q0.push_back(10'h3FF);
    wait_gnt("t5_gnt_timeout");
    wait_idle("t5_idle_timeout");
    repeat (3) @(negedge clk);
    chk(gnt_cnt - gb == 1, "t5_one_read", gnt_cnt - gb, 1);
    chk(state_dbg == ST_IDLE, "t5_state", state_dbg, ST_IDLE);
    check_drained("t5_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 10, word width of all data buses.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports in0_empty, in1_empty  input  1 each  empty flags of the two upstream FIFOs.
REQ-005 SHALL have ports in0_data, in1_data  input  DATA_W each  upstream FIFO data_out, valid the cycle after the matching rd_enb.
REQ-006 SHALL have ports in0_rd_enb, in1_rd_enb  output  1 each  pop requests to the upstream FIFOs.
REQ-007 SHALL have ports out0_alm_full, out1_alm_full  input  1 each  almost-full flags of the two downstream FIFOs.
REQ-008 SHALL have ports out0_wr_enb, out1_wr_enb  output  1 each  push strobes to the downstream FIFOs.
REQ-009 SHALL have port out_data  output  DATA_W  shared downstream write data.
REQ-010 SHALL have port idle  output  1  high when the FSM is in IDLE.

Function
REQ-011 SHALL assert at most one inX_rd_enb per cycle; back-to-back reads are allowed.
REQ-012 SHALL assert inX_rd_enb only when inX_empty=0 and both out0_alm_full and out1_alm_full are 0. The destination is unknown before the read, and alm_full thresholds leave room for 2 in-flight words.
REQ-013 SHALL grant round-robin:
- if both inputs are non-empty, grant the input not granted last;
- if one input is non-empty, grant it;
- the pointer updates only on a grant.
REQ-014 SHALL capture inX_data in the cycle after the grant (N+1), then register it. out_data and exactly one outY_wr_enb are high in cycle N+2, a fixed 2-cycle latency.
REQ-015 SHALL route on bit DATA_W-1 of the captured word: 0 -> out0_wr_enb, 1 -> out1_wr_enb. The word passes unmodified.
REQ-016 SHALL hold out_data at its last value and both outY_wr_enb at 0 when no word is in flight.
REQ-017 SHALL complete words already in flight even if alm_full rises; alm_full only blocks new grants.
REQ-018 SHALL implement FSM states RESET, IDLE and ACTIVE:
- RESET -> IDLE on the first edge after rst deasserts;
- IDLE -> ACTIVE when a grant is issued;
- ACTIVE -> IDLE when no grant is issued in the current cycle and the pipeline holds no in-flight word.
REQ-019 SHALL issue no grant in RESET.

Reset
REQ-020 SHALL, while rst=0, immediately force:
- all rd_enb and wr_enb = 0;
- out_data = 0;
- idle = 0;
- state = RESET;
- RR pointer = in0.
REQ-021 SHALL discard in-flight words on reset mid-operation, with no downstream write after rst deasserts.

Configuration
REQ-022 SHALL support macro FIFO_ARBITER_STRICT_PRIO_EN:
- defined: in0 always wins when non-empty (strict priority);
- undefined: round-robin per REQ-013.
All other behaviour is identical in both builds.

Structure
REQ-023 SHALL place the state enum (RESET/IDLE/ACTIVE) and the default DATA_W constant in shared package fifo_arbiter_pkg.
REQ-024 SHALL implement grant selection as sub-module arb_rr_grant (combinational: empties, block, pointer -> grants), instantiated once.

Verification
REQ-025 The bench SHALL cover: in0 holds 0x005 and 0x20A, in1 empty -> in0_rd_enb at N and N+1; out0_wr_enb with 0x005 at N+2; out1_wr_enb with 0x20A at N+3.
REQ-026 The bench SHALL cover: both inputs non-empty with 3 words each -> grants alternate in0,in1,in0,in1,in0,in1, then idle=1 two cycles after the last write. Under FIFO_ARBITER_STRICT_PRIO_EN -> in0 x3, then in1 x3.
REQ-027 The bench SHALL cover: out1_alm_full=1 while inputs are non-empty -> no rd_enb; the 2 words in flight are still written. alm_full=0 -> grants resume the next cycle.
REQ-028 The bench SHALL cover: rst=0 asserted the cycle after a grant -> outputs 0 immediately; no wr_enb after release; idle=1 one cycle after release.
REQ-029 The bench SHALL cover: in0 holds a single word 0x3FF -> one read only, no read while empty=1; out1_wr_enb with 0x3FF; FSM returns to IDLE.
